simon_autoplayer: RTL and testbench

- Self-playing opponent for the b12 memory game: drives the game's start/k inputs and observes its nl/nloss outputs.
- Watches each playback phase and records the colour sequence from LED onsets.
- Replays the recorded sequence as one-hot key presses, each held until the game echoes it.
- Used as a closed-loop stimulus source for long-run property checking; an optional fault-injection round exercises the loss path.

---
 rtl/simon_autoplayer_if.sv | 11 +
 rtl/simon_autoplayer.sv | 230 +++++++++++++++++++++++
 tb/tb_simon_autoplayer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/simon_autoplayer_if.sv
// Game-side connection between the b12 memory game and its automatic player.
// The player is the master: it drives start/k and watches nl/nloss.
interface simon_autoplayer_if;
  logic       start;
  logic [3:0] k;
  logic [3:0] nl;
  logic       nloss;

  modport master (output start, output k, input nl, input nloss);
  modport slave  (input start, input k, output nl, output nloss);
endinterface

// File: rtl/simon_autoplayer.sv
// Closed-loop opponent for the b12 memory game: records each playback from LED
// onsets, then replays it as one-hot key presses held until the game echoes them.
module simon_autoplayer #(
  parameter int DEPTH       = 32,
  parameter int GAP_TIMEOUT = 80,
  parameter int KEY_TIMEOUT = 80
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [5:0]          miss_round,
  simon_autoplayer_if.master  game,
  output logic [5:0]          round,
  output logic                won,
  output logic                lost,
  output logic                error
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WATCH, S_PRESS, S_RELEASE, S_HALT
  } state_t;

  state_t     r_state, w_state;
  logic [3:0] r_nlPrev;
  logic       r_nlossPrev;
  logic [3:0] r_k, w_k;
  logic [5:0] r_round, w_round;
  logic       r_won, w_won;
  logic       r_lost, w_lost;
  logic       r_error, w_error;
  logic [5:0] r_wptr, w_wptr;
  logic [5:0] r_rptr, w_rptr;
  logic [7:0] r_gap, w_gap;
  logic [7:0] r_keyTimer, w_keyTimer;
  logic [1:0] r_mem [DEPTH];

  logic       w_memWe;
  logic       w_onset;
  logic       w_nlossRise;
  logic       w_isOneHot;
  logic [1:0] w_colour;
  logic [5:0] w_keyIdx;
  logic [5:0] w_keyRound;
  logic       w_keyMiss;
  logic [1:0] w_keyColour;
  logic [3:0] w_keyOnehot;

  assign w_onset     = (game.nl != 4'd0) && (r_nlPrev == 4'd0);
  assign w_nlossRise = game.nloss && !r_nlossPrev;
  assign w_isOneHot  = (game.nl != 4'd0) && ((game.nl & (game.nl - 4'd1)) == 4'd0);

  always_comb begin
    w_colour = 2'd0;
    case (game.nl)
      4'b0010: w_colour = 2'd1;
      4'b0100: w_colour = 2'd2;
      4'b1000: w_colour = 2'd3;
      default: w_colour = 2'd0;
    endcase
  end

  // Key for the press being entered: the first press of a round follows a WATCH
  // exit (round not yet updated), later ones follow a RELEASE.
  assign w_keyIdx    = (r_state == S_WATCH) ? 6'd0 : 6'(r_rptr + 6'd1);
  assign w_keyRound  = (r_state == S_WATCH) ? r_wptr : r_round;
  assign w_keyMiss   = (w_keyIdx == 6'd0) && (w_keyRound == miss_round);
  assign w_keyColour = r_mem[w_keyIdx[AW-1:0]] + {1'b0, w_keyMiss};
  assign w_keyOnehot = 4'b0001 << w_keyColour;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_nlPrev    <= 4'd0;
      r_nlossPrev <= 1'b0;
      r_k         <= 4'd0;
      r_round     <= 6'd0;
      r_won       <= 1'b0;
      r_lost      <= 1'b0;
      r_error     <= 1'b0;
      r_wptr      <= 6'd0;
      r_rptr      <= 6'd0;
      r_gap       <= 8'd0;
      r_keyTimer  <= 8'd0;
    end else begin
      r_state     <= w_state;
      r_nlPrev    <= game.nl;
      r_nlossPrev <= game.nloss;
      r_k         <= w_k;
      r_round     <= w_round;
      r_won       <= w_won;
      r_lost      <= w_lost;
      r_error     <= w_error;
      r_wptr      <= w_wptr;
      r_rptr      <= w_rptr;
      r_gap       <= w_gap;
      r_keyTimer  <= w_keyTimer;
    end
  end

  // Sequence memory is not reset; stale contents are never read before rewrite.
  always_ff @(posedge clock) begin
    if (w_memWe) begin
      r_mem[r_wptr[AW-1:0]] <= w_colour;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_k        = r_k;
    w_round    = r_round;
    w_won      = r_won;
    w_lost     = r_lost;
    w_error    = r_error;
    w_wptr     = r_wptr;
    w_rptr     = r_rptr;
    w_gap      = r_gap;
    w_keyTimer = r_keyTimer;
    w_memWe    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state = S_START;
          w_won   = 1'b0;
          w_lost  = 1'b0;
          w_error = 1'b0;
          w_round = 6'd0;
        end
      end
      S_START: begin
        w_wptr  = 6'd0;
        w_rptr  = 6'd0;
        w_gap   = 8'd0;
        w_k     = 4'd0;
        w_state = S_WATCH;
      end
      S_WATCH, S_PRESS, S_RELEASE: begin
        // Loss, win and malformed LEDs override whatever the phase is doing.
        if (w_nlossRise) begin
          w_lost  = 1'b1;
          w_k     = 4'd0;
          w_state = S_HALT;
        end else if (game.nl == 4'hF) begin
          w_won   = 1'b1;
          w_k     = 4'd0;
          w_state = S_HALT;
        end else if (game.nl != 4'd0 && !w_isOneHot) begin
          w_error = 1'b1;
          w_k     = 4'd0;
          w_state = S_HALT;
        end else begin
          case (r_state)
            S_WATCH: begin
              if (w_onset) begin
                if (r_wptr == 6'(DEPTH)) begin
                  w_error = 1'b1;
                  w_state = S_HALT;
                end else begin
                  w_memWe = 1'b1;
                  w_wptr  = 6'(r_wptr + 6'd1);
                  w_gap   = 8'd0;
                end
              end else if (game.nl == 4'd0 && r_wptr != 6'd0) begin
                if (r_gap == 8'(GAP_TIMEOUT)) begin
                  w_round    = r_wptr;
                  w_rptr     = 6'd0;
                  w_gap      = 8'd0;
                  w_k        = w_keyOnehot;
                  w_keyTimer = 8'd0;
                  w_state    = S_PRESS;
                end else if (r_gap != 8'hFF) begin
                  w_gap = 8'(r_gap + 8'd1);
                end
              end
            end
            S_PRESS: begin
              if (w_onset) begin
                w_k = 4'd0;
                if (game.nl != r_k) begin
                  w_error = 1'b1;
                  w_state = S_HALT;
                end else begin
                  w_state = S_RELEASE;
                end
              end else if (r_keyTimer == 8'(KEY_TIMEOUT - 1)) begin
                w_error = 1'b1;
                w_k     = 4'd0;
                w_state = S_HALT;
              end else if (r_keyTimer != 8'hFF) begin
                w_keyTimer = 8'(r_keyTimer + 8'd1);
              end
            end
            default: begin
              if (game.nl == 4'd0) begin
                if (r_rptr == 6'(r_round - 6'd1)) begin
                  w_wptr  = 6'd0;
                  w_gap   = 8'd0;
                  w_state = S_WATCH;
                end else begin
                  w_rptr     = 6'(r_rptr + 6'd1);
                  w_k        = w_keyOnehot;
                  w_keyTimer = 8'd0;
                  w_state    = S_PRESS;
                end
              end
            end
          endcase
        end
      end
      default: begin
        w_k = 4'd0;
      end
    endcase

    if (!enable && r_state != S_IDLE) begin
      w_state = S_IDLE;
      w_k     = 4'd0;
    end
  end

  assign game.start = (r_state == S_START);
  assign game.k     = r_k;
  assign round      = r_round;
  assign won        = r_won;
  assign lost       = r_lost;
  assign error      = r_error;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Bench for simon_autoplayer: a behavioural b12 game model plays randomized
// sequences against the player and scores its keys, round count and flags.
module tb_simon_autoplayer;

  localparam int DEPTH       = 32;
  localparam int GAP_TIMEOUT = 80;
  localparam int KEY_TIMEOUT = 80;

  logic       clock = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable;
  logic [5:0] miss_round;
  logic [5:0] round;
  logic       won;
  logic       lost;
  logic       error;

  int checks = 0;
  int passes = 0;
  int seq [DEPTH+1];

  simon_autoplayer_if gif ();

  simon_autoplayer #(
    .DEPTH(DEPTH), .GAP_TIMEOUT(GAP_TIMEOUT), .KEY_TIMEOUT(KEY_TIMEOUT)
  ) dut (
    .clock(clock), .rst_n(rst_n), .enable(enable), .miss_round(miss_round),
    .game(gif), .round(round), .won(won), .lost(lost), .error(error)
  );

  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] oneHot(input int c);
    logic [1:0] idx;
    idx = 2'(c);
    return 4'b0001 << idx;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Game side: hold nl at a value for a number of cycles (called at a negedge).
  task automatic applyStimulus(input logic [3:0] nlVal, input int cycles);
    gif.nl = nlVal;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic doReset();
    enable     = 1'b0;
    miss_round = 6'd0;
    gif.nl     = 4'd0;
    gif.nloss  = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic startGame();
    enable = 1'b1;
    @(negedge clock);
    checkOutput("startPulse", 32'(gif.start), 32'd1);
    @(negedge clock);
    checkOutput("startOneCycle", 32'(gif.start), 32'd0);
  endtask

  task automatic playRound(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(oneHot(seq[i]), $urandom_range(2, 5));
      applyStimulus(4'd0, $urandom_range(3, 6));
    end
  endtask

  task automatic waitKey();
    for (int t = 0; t < 300 && gif.k == 4'd0; t++) @(negedge clock);
  endtask

  // Game model: each key must equal the sequence entry, otherwise nloss rises.
  task automatic pressRound(input int r, input int missRound, output bit lostGame);
    int expColour;
    lostGame = 1'b0;
    for (int i = 0; i < r; i++) begin
      waitKey();
      expColour = (r == missRound && i == 0) ? (seq[0] + 1) % 4 : seq[i];
      if (i == 0) checkOutput("round", 32'(round), 32'(r));
      checkOutput("key", 32'(gif.k), 32'(oneHot(expColour)));
      if (gif.k != oneHot(seq[i])) begin
        gif.nloss = 1'b1;
        lostGame  = 1'b1;
        return;
      end
      applyStimulus(oneHot(seq[i]), $urandom_range(2, 4));
      checkOutput("keyReleased", 32'(gif.k), 32'd0);
      applyStimulus(4'd0, $urandom_range(3, 5));
    end
  endtask

  initial begin
    bit lostGame;
    int held;

    enable     = 1'b0;
    miss_round = 6'd0;
    gif.nl     = 4'd0;
    gif.nloss  = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rstRound", 32'(round), 32'd0);
    checkOutput("rstK", 32'(gif.k), 32'd0);
    checkOutput("rstStart", 32'(gif.start), 32'd0);
    checkOutput("rstWon", 32'(won), 32'd0);
    checkOutput("rstLost", 32'(lost), 32'd0);
    checkOutput("rstError", 32'(error), 32'd0);
    rst_n = 1'b1;
    @(negedge clock);

    $display("[TB] full game, miss_round=0");
    for (int i = 0; i < DEPTH; i++) seq[i] = $urandom_range(0, 3);
    seq[0] = 1;
    startGame();
    for (int r = 1; r <= DEPTH; r++) begin
      playRound(r);
      pressRound(r, 0, lostGame);
    end
    applyStimulus(4'hF, 3);
    applyStimulus(4'd0, 2);
    checkOutput("winWon", 32'(won), 32'd1);
    checkOutput("winLost", 32'(lost), 32'd0);
    checkOutput("winError", 32'(error), 32'd0);
    checkOutput("winK", 32'(gif.k), 32'd0);
    checkOutput("winRound", 32'(round), 32'(DEPTH));

    $display("[TB] reset during a key press");
    doReset();
    seq[0] = 2;
    startGame();
    playRound(1);
    waitKey();
    checkOutput("pressKey", 32'(gif.k), 32'h4);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstK", 32'(gif.k), 32'd0);
    checkOutput("asyncRstRound", 32'(round), 32'd0);
    checkOutput("asyncRstStart", 32'(gif.start), 32'd0);
    @(negedge clock);

    $display("[TB] deliberate miss in round 3");
    doReset();
    seq[0] = 2; seq[1] = 0; seq[2] = 1;
    miss_round = 6'd3;
    startGame();
    for (int r = 1; r <= 3; r++) begin
      playRound(r);
      pressRound(r, 3, lostGame);
      if (lostGame) break;
    end
    @(negedge clock);
    checkOutput("missLost", 32'(lost), 32'd1);
    checkOutput("missK", 32'(gif.k), 32'd0);
    checkOutput("missError", 32'(error), 32'd0);
    repeat (4) @(negedge clock);
    checkOutput("haltK", 32'(gif.k), 32'd0);
    checkOutput("haltStart", 32'(gif.start), 32'd0);
    checkOutput("haltRound", 32'(round), 32'd3);

    $display("[TB] unanswered key");
    doReset();
    seq[0] = $urandom_range(0, 3);
    startGame();
    playRound(1);
    waitKey();
    held = 0;
    for (int t = 0; t < 300 && !error; t++) begin
      if (gif.k != 4'd0) held++;
      @(negedge clock);
    end
    checkOutput("keyHeldCycles", 32'(held), 32'(KEY_TIMEOUT));
    checkOutput("keyTimeoutError", 32'(error), 32'd1);
    checkOutput("keyTimeoutK", 32'(gif.k), 32'd0);

    $display("[TB] malformed LED pattern");
    doReset();
    startGame();
    applyStimulus(4'b0110, 2);
    checkOutput("protoError", 32'(error), 32'd1);
    checkOutput("protoWon", 32'(won), 32'd0);
    applyStimulus(4'd0, 2);
    checkOutput("protoRound", 32'(round), 32'd0);

    $display("[TB] playback longer than memory");
    doReset();
    startGame();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(oneHot($urandom_range(0, 3)), 2);
      applyStimulus(4'd0, 3);
    end
    checkOutput("fullNoError", 32'(error), 32'd0);
    applyStimulus(oneHot($urandom_range(0, 3)), 2);
    checkOutput("overflowError", 32'(error), 32'd1);
    applyStimulus(4'd0, 2);

    $display("[TB] enable dropped mid-press");
    doReset();
    seq[0] = $urandom_range(0, 3);
    startGame();
    playRound(1);
    waitKey();
    checkOutput("dropKeyBefore", 32'(gif.k), 32'(oneHot(seq[0])));
    enable = 1'b0;
    @(negedge clock);
    checkOutput("dropKey", 32'(gif.k), 32'd0);
    startGame();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
